// File: rtl/fm_stim_driver_pkg.sv
// Shared encodings and defaults for the fundamental-mode stimulus driver.
package fm_stim_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam int RES_X1 = 3;
  localparam int RES_X2 = 2;
  localparam int RES_Z1 = 1;
  localparam int RES_Z2 = 0;

  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_FIFO_DEPTH    = 4;

endpackage

// File: rtl/fm_stim_driver_sync.sv
// Multi-flop synchroniser for one asynchronous FSM output bit; clears to 0 on reset.
module fm_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/fm_stim_driver.sv
// Drives X1/X2 of a fundamental-mode async FSM one input change at a time and reports {X1,X2,Z1,Z2}.
// Optional hazard detection on the synchronised Z outputs is enabled by FM_STIM_HAZARD_CHECK_EN.
module fm_stim_driver
  import fm_stim_driver_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vec_valid,
  output logic       vec_ready,
  input  logic [1:0] vec_data,
  output logic       X1,
  output logic       X2,
  input  logic       Z1,
  input  logic       Z2,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_unstable,
  output logic       busy
);

  localparam int N       = SETTLE_CYCLES + SYNC_STAGES;
  localparam int CNT_W   = $clog2(N) + 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int QCNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N - 1);

  logic w_zs1;
  logic w_zs2;

  fm_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_z1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (Z1),
    .o_q   (w_zs1)
  );

  fm_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_z2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (Z2),
    .o_q   (w_zs2)
  );

  // Input vector queue: circular buffer, storage itself is not reset.
  logic [1:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [QCNT_W-1:0] r_count;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  assign w_full    = (r_count == QCNT_W'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign vec_ready = !w_full;
  assign w_push    = vec_valid && !w_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= vec_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + QCNT_W'(1);
        2'b01:   r_count <= r_count - QCNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             r_pend;
  logic             w_pend_nx;
  logic [1:0]       r_x;
  logic [1:0]       w_x_nx;
  logic             r_res_valid;
  logic             w_res_valid_nx;
  logic [3:0]       r_res_data;
  logic [3:0]       w_res_data_nx;
  logic [1:0]       w_tgt;
  logic [1:0]       w_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_x         <= 2'b00;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_pend      <= w_pend_nx;
      r_x         <= w_x_nx;
      r_res_valid <= w_res_valid_nx;
      r_res_data  <= w_res_data_nx;
    end
  end

  // A two-bit change is split: X1 moves first, X2 only after a full settle window.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_pend_nx      = r_pend;
    w_x_nx         = r_x;
    w_res_valid_nx = r_res_valid;
    w_res_data_nx  = r_res_data;
    w_pop          = 1'b0;
    w_tgt          = r_mem[r_rd_ptr];
    w_diff         = 2'b00;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_diff     = w_tgt ^ r_x;
          w_state_nx = ST_SETTLE;
          w_cnt_nx   = CNT_LOAD;
          if (w_diff == 2'b11) begin
            w_x_nx[1] = ~r_x[1];
            w_pend_nx = 1'b1;
          end else begin
            w_x_nx = w_tgt;
          end
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          if (r_pend) begin
            w_x_nx[0] = ~r_x[0];
            w_pend_nx = 1'b0;
            w_cnt_nx  = CNT_LOAD;
          end else begin
            w_state_nx = ST_SAMPLE;
          end
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        w_res_valid_nx         = 1'b1;
        w_res_data_nx[RES_X1]  = r_x[1];
        w_res_data_nx[RES_X2]  = r_x[0];
        w_res_data_nx[RES_Z1]  = w_zs1;
        w_res_data_nx[RES_Z2]  = w_zs2;
        w_state_nx             = ST_REPORT;
      end
      ST_REPORT: begin
        if (res_ready) begin
          w_res_valid_nx = 1'b0;
          w_state_nx     = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

`ifdef FM_STIM_HAZARD_CHECK_EN
  // Any Zs movement in the tail of the last settle window means the FSM was not yet stable.
  logic [1:0] r_zs_prev;
  logic       r_hz_flag;
  logic       r_unstable;
  logic       w_in_window;

  assign w_in_window = (r_state == ST_SETTLE) && !r_pend &&
                       (r_cnt <= CNT_W'(SYNC_STAGES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zs_prev  <= 2'b00;
      r_hz_flag  <= 1'b0;
      r_unstable <= 1'b0;
    end else begin
      r_zs_prev <= {w_zs1, w_zs2};
      if (w_pop) begin
        r_hz_flag <= 1'b0;
      end else if (w_in_window && ({w_zs1, w_zs2} != r_zs_prev)) begin
        r_hz_flag <= 1'b1;
      end
      if (r_state == ST_SAMPLE) begin
        r_unstable <= r_hz_flag;
      end
    end
  end

  assign res_unstable = r_unstable;
`else
  assign res_unstable = 1'b0;
`endif

  assign X1        = r_x[1];
  assign X2        = r_x[0];
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: doc/fm_stim_driver.md
Name: fm_stim_driver

Overview:
- Clocked driver for a two-input, two-output fundamental-mode asynchronous state machine (inputs X1/X2, outputs Z1/Z2).
- Accepts queued 2-bit input vectors and applies them to X1/X2 so that only one input changes at a time, and only once the machine has settled.
- Synchronises Z1/Z2, samples them after a settle window and returns one {X1,X2,Z1,Z2} result per vector over a valid/ready handshake.
- Sits between the test/control logic and the asynchronous FSM instance.

Parameters:
- SETTLE_CYCLES, 4, clock cycles to wait after any X edge before sampling (min 1).
- SYNC_STAGES, 2, flops in the Z1/Z2 synchroniser (min 2).
- FIFO_DEPTH, 4, input vector queue entries (power of 2, min 2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- vec_valid  in  1  input vector offered.
- vec_ready  out  1  queue can accept; equals !full (combinational from count).
- vec_data  in  2  target inputs; [1]=X1, [0]=X2.
- X1  out  1  registered drive to FSM input X1.
- X2  out  1  registered drive to FSM input X2.
- Z1  in  1  asynchronous FSM output.
- Z2  in  1  asynchronous FSM output.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  4  {X1,X2,Z1,Z2} as sampled.
- res_unstable  out  1  hazard flag; tied 0 unless the option is enabled.
- busy  out  1  high whenever state != IDLE or the queue is non-empty.

Behaviour:
- Reset (async, rst_n=0) forces:
  - X1=X2=0, queue empty, res_valid=0, res_data=0, res_unstable=0.
  - Synchroniser flops 0, state IDLE, settle counter 0.
- Reset mid-operation abandons any vector in flight or queued; outputs reach reset values immediately.
- Push occurs when vec_valid && vec_ready. No push while full, even if a pop happens in the same cycle. A push into an empty queue is poppable the next cycle.
- Define N = SETTLE_CYCLES + SYNC_STAGES.
- IDLE:
  - If the queue is non-empty, pop into tgt and compute diff = tgt ^ {X1,X2}.
  - diff=00: go to SETTLE with no X change (pure re-sample).
  - diff=01 or 10: toggle that X bit on the same edge, go to SETTLE.
  - diff=11: toggle X1 only, set pend=1, go to SETTLE.
- SETTLE: counter loads N-1 on entry and decrements each cycle. At 0:
  - If pend: toggle X2, clear pend, reload, stay in SETTLE.
  - Otherwise go to SAMPLE.
- SAMPLE (1 cycle): res_data <= {X1,X2,Zs1,Zs2} using the synchronised Z values; res_valid <= 1; go to REPORT.
- REPORT: hold res_valid and res_data stable until res_ready=1. The handshake edge clears res_valid and returns to IDLE. The next pop can occur on the following cycle.
- Latency with res_ready=1 (pop edge = cycle 0):
  - Single-bit or zero diff: res_valid rises at cycle N+1 (defaults: 7).
  - Two-bit diff: X2 toggles at cycle N; res_valid rises at cycle 2N+1 (defaults: 13).
- X1 and X2 never change on the same edge. Both are flop outputs only, so they are glitch-free.
- The intermediate state of a two-bit change is never reported.
- Result backpressure stalls the FSM only; the queue keeps accepting until full.

Optional Feature:
- Macro: FM_STIM_HAZARD_CHECK_EN.
- Defined:
  - During the final SYNC_STAGES+1 cycles of each final settle window, Zs1/Zs2 are compared to their previous-cycle values.
  - Any change sets a sticky flag, cleared on SETTLE entry.
  - SAMPLE copies the flag to res_unstable, held with res_data.
- Undefined: the compare logic is absent and res_unstable is constant 0.

Decomposition:
- Shared package/header holds:
  - State encodings IDLE/SETTLE/SAMPLE/REPORT (2-bit).
  - res_data field indices (RES_X1=3, RES_X2=2, RES_Z1=1, RES_Z2=0).
  - Default parameter constants.
- One sub-module, fm_sync_bit: parameterised SYNC_STAGES flop chain with async active-low reset to 0, instanced once per Z input.
- The FIFO stays inline (pointer + count).

Test Plan:
- Reset: hold rst_n=0 with random Z inputs; X1=X2=0, res_valid=0, vec_ready=1, busy=0. Release reset; outputs stay unchanged until the first push.
- Single change: push 2'b10 with the FSM model attached; X1 rises on the pop edge, X2 stays 0, res_valid rises 7 cycles later with res_data[3:2]=10 and Z matching the model.
- Double change: from X=00 push 2'b11; X1 rises at cycle 0, X2 at cycle 6, exactly one result at cycle 13 with res_data[3:2]=11.
- Backpressure: res_ready=0 for 30 cycles, push 6 vectors; after 1 pop vec_ready drops once 4 are queued. res_data stays constant while stalled, then all 5 remaining results drain in order.
- Zero diff / reset mid-op: push the current X value; result appears 7 cycles after the pop with X unchanged. Assert rst_n=0 at cycle 3 of a settle; X returns to 00 asynchronously and no result is produced.
- Hazard (macro defined): pulse Z1 for 1 cycle at cycle 5 of the window; res_unstable=1. The same stimulus with the macro undefined gives res_unstable=0.
